// File: rtl/decbcd_pkg.sv
// Shared definitions for the decimal-to-BCD key encoder and the BCD decoder bench:
// FSM state encodings, key-vector classes and the BCD code constants for digits 0..9.
package decbcd_pkg;

  localparam int NUM_KEYS = 10;

  // Encoder FSM states (kept as plain constants so legacy tools can read them)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Classification of the synchronized key vector
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } key_class_e;

  // BCD codes for decimal digits
  localparam logic [3:0] BCD_0 = 4'b0000;
  localparam logic [3:0] BCD_1 = 4'b0001;
  localparam logic [3:0] BCD_2 = 4'b0010;
  localparam logic [3:0] BCD_3 = 4'b0011;
  localparam logic [3:0] BCD_4 = 4'b0100;
  localparam logic [3:0] BCD_5 = 4'b0101;
  localparam logic [3:0] BCD_6 = 4'b0110;
  localparam logic [3:0] BCD_7 = 4'b0111;
  localparam logic [3:0] BCD_8 = 4'b1000;
  localparam logic [3:0] BCD_9 = 4'b1001;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for one asynchronous key line.
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives the settled sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/decbcd_keyenc.sv
// Decimal-to-BCD key encoder: synchronizes ten key lines, debounces press and
// release, rejects multi-key presses and emits the BCD code with a one-cycle valid.
module decbcd_keyenc
  import decbcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic d8,
  input  logic d9,
  output logic a0,
  output logic a1,
  output logic a2,
  output logic a3,
  output logic valid,
  output logic err,
  output logic busy
);

  // Counter value at which the final required stable sample is being seen
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] d_raw;
  logic [NUM_KEYS-1:0] ks;
  logic [3:0]          ks_cnt;
  logic [3:0]          ks_code;
  key_class_e          ks_cls;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q;

  assign d_raw = {d9, d8, d7, d6, d5, d4, d3, d2, d1, d0};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    key_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (d_raw[i]),
      .q_o   (ks[i])
    );
  end

  // Count asserted lines and encode the (only meaningful when single) asserted index
  always_comb begin
    ks_cnt  = 4'd0;
    ks_code = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      ks_cnt = ks_cnt + {3'b000, ks[i]};
      if (ks[i]) ks_code = 4'(i);
    end
  end

  // Reduce the count to none / exactly one / several keys
  always_comb begin
    ks_cls = CLS_NONE;
    if (ks_cnt == 4'd1) begin
      ks_cls = CLS_ONE;
    end else if (ks_cnt != 4'd0) begin
      ks_cls = CLS_MULTI;
    end
  end

  // Next-state logic: debounce the press, hold while pressed, debounce the release
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        case (ks_cls)
          CLS_NONE: err_d = 1'b0;
          CLS_ONE: begin
            cand_d  = ks_code;
            cnt_d   = CNT_ONE;
            state_d = ST_DEBOUNCE;
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_DEBOUNCE: begin
        if (ks_cls == CLS_ONE && ks_code == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            code_d  = cand_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_IDLE;
          if (ks_cls == CLS_MULTI) err_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ks_cls == CLS_NONE) begin
          cnt_d   = CNT_ONE;
          state_d = ST_RELEASE;
        end else if (ks_cls == CLS_MULTI) begin
          err_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (ks_cls == CLS_NONE) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Bounce during release: back to holding, never re-encoded
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any press in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign a0    = code_q[0];
  assign a1    = code_q[1];
  assign a2    = code_q[2];
  assign a3    = code_q[3];
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_decbcd_keyenc.sv
// Bench for decbcd_keyenc: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_decbcd_keyenc;
  import decbcd_pkg::*;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] dvec;
  logic       a0, a1, a2, a3, valid, err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  decbcd_keyenc #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(dvec[0]), .d1(dvec[1]), .d2(dvec[2]), .d3(dvec[3]), .d4(dvec[4]),
    .d5(dvec[5]), .d6(dvec[6]), .d7(dvec[7]), .d8(dvec[8]), .d9(dvec[9]),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model ----------------
  logic [9:0] m_s1, m_s2;      // two-sample delay of the raw keys
  int         m_mode;          // 0 waiting, 1 qualifying, 2 held, 3 releasing
  int         m_run;           // consecutive qualifying / quiet samples seen
  int         m_key;
  logic [3:0] m_code;
  logic       m_valid, m_err, m_busy;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_mode = 0; m_run = 0; m_key = 0;
    m_code = 4'd0; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] dn);
    int n;
    int k;
    n = $countones(m_s2);
    k = 0;
    for (int i = 0; i < 10; i++) if (m_s2[i]) k = i;
    m_valid = 1'b0;
    case (m_mode)
      0: begin
        if (n == 1) begin m_key = k; m_run = 1; m_mode = 1; end
        else m_err = (n > 1);
      end
      1: begin
        if (n == 1 && k == m_key) begin
          m_run++;
          if (m_run == DC) begin m_code = 4'(m_key); m_valid = 1'b1; m_mode = 2; end
        end else begin
          m_mode = 0;
          if (n > 1) m_err = 1'b1;
        end
      end
      2: begin
        if (n == 0) begin m_mode = 3; m_run = 1; end
        else if (n > 1) m_err = 1'b1;
      end
      default: begin
        if (n == 0) begin
          m_run++;
          if (m_run == DC) begin m_mode = 0; m_err = 1'b0; end
        end else m_mode = 2;
      end
    endcase
    m_busy = (m_mode != 0);
    m_s2 = m_s1;
    m_s1 = dn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(dvec);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  int         vcount = 0;
  logic [3:0] vcodes[$];
  int         first_v = -1;
  int         first_err = -1;
  int         last_busy = -1;
  bit         err_seen = 0;
  bit         busy_seen = 0;

  initial forever begin
    @(negedge clk);
    chk("code", int'({a3, a2, a1, a0}), int'(m_code));
    chk("valid", int'(valid), int'(m_valid));
    chk("err", int'(err), int'(m_err));
    chk("busy", int'(busy), int'(m_busy));
    if (valid) begin
      vcount++;
      vcodes.push_back({a3, a2, a1, a0});
      if (first_v < 0) first_v = cyc;
    end
    if (err) begin
      err_seen = 1;
      if (first_err < 0) first_err = cyc;
    end
    if (busy) begin
      busy_seen = 1;
      last_busy = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- stimulus ----------------
  int rel, vc0, mark;

  initial begin
    rst_n = 1'b0;
    dvec  = 10'd0;

    // Scenario 1: d7 held through reset, then released from reset
    dvec = 10'd1 << 7;
    tick(3);
    chk("reset_code", int'({a3, a2, a1, a0}), 0);
    chk("reset_busy", int'(busy), 0);
    vc0 = vcount; first_v = -1;
    rst_n = 1'b1;
    rel = cyc;
    tick(10);
    chk("s1_latency", first_v - rel, 6);
    chk("s1_count", vcount - vc0, 1);
    chk("s1_code", int'({a3, a2, a1, a0}), int'(BCD_7));
    dvec = 10'd0;
    tick(10);

    // Scenario 2: every key in turn
    vcodes.delete();
    vc0 = vcount; err_seen = 0;
    for (int i = 0; i < 10; i++) begin
      dvec = 10'd1 << i;
      tick(8);
      dvec = 10'd0;
      tick(8);
    end
    chk("s2_count", vcount - vc0, 10);
    for (int i = 0; i < 10; i++)
      if (i < vcodes.size()) chk("s2_seq", int'(vcodes[i]), i);
    chk("s2_err", int'(err_seen), 0);

    // Scenario 3: short glitch on d3
    vc0 = vcount; busy_seen = 0;
    dvec = 10'd1 << 3;
    tick(2);
    dvec = 10'd0;
    tick(10);
    chk("s3_count", vcount - vc0, 0);
    chk("s3_busy_seen", int'(busy_seen), 1);
    chk("s3_busy_end", int'(busy), 0);
    chk("s3_code", int'({a3, a2, a1, a0}), int'(BCD_9));

    // Scenario 4: two keys together
    vc0 = vcount; first_err = -1;
    dvec = (10'd1 << 2) | (10'd1 << 5);
    mark = cyc;
    tick(6);
    chk("s4_err_within3", int'(first_err >= 0 && first_err - mark <= 3), 1);
    dvec = 10'd0;
    tick(10);
    chk("s4_err_clear", int'(err), 0);
    chk("s4_count", vcount - vc0, 0);

    // Scenario 5: accepted d9 with a bouncing release
    vc0 = vcount;
    dvec = 10'd1 << 9;
    tick(8);
    dvec = 10'd0;
    tick(1);
    dvec = 10'd1 << 9;
    tick(1);
    dvec = 10'd0;
    mark = cyc;
    tick(12);
    chk("s5_count", vcount - vc0, 1);
    chk("s5_code", int'({a3, a2, a1, a0}), int'(BCD_9));
    chk("s5_idle_at", last_busy - mark, 5);

    // Scenario 6: reset pulse while d4 is being debounced
    dvec = 10'd1 << 4;
    tick(3);
    chk("s6_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_code", int'({a3, a2, a1, a0}), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_valid", int'(valid), 0);
    chk("s6_rst_err", int'(err), 0);
    tick(1);
    vc0 = vcount; first_v = -1;
    rst_n = 1'b1;
    rel = cyc;
    tick(10);
    chk("s6_latency", first_v - rel, 6);
    chk("s6_count", vcount - vc0, 1);
    chk("s6_code", int'({a3, a2, a1, a0}), int'(BCD_4));
    dvec = 10'd0;
    tick(10);

    // Randomized traffic: quiet, single keys, multi-key, occasional reset
    for (int s = 0; s < 400; s++) begin
      int r;
      int k1;
      int k2;
      r  = $urandom_range(0, 9);
      k1 = $urandom_range(0, 9);
      k2 = $urandom_range(0, 9);
      if (r < 3) dvec = 10'd0;
      else if (r < 8) dvec = 10'd1 << k1;
      else dvec = (10'd1 << k1) | (10'd1 << k2) | (10'd1 << ((k1 + 1) % 10));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 10));
    end
    dvec = 10'd0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
